// File: rtl/streaming_fifo_pkg.sv
// Shared helpers for the parametrised streaming FIFO: count-bus sizing and
// non-power-of-two pointer wrap.
package streaming_fifo_pkg;

  // Bits needed to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment that wraps at depth-1 without power-of-two masking.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/streaming_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and a combinational
// read port, kept separate from control so it can map to LUTRAM or BRAM.
module streaming_fifo_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 784,
  parameter int unsigned PW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately unreset; validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/streaming_fifo_param.sv
// Parametrised AXI-Stream FIFO with arbitrary depth, almost flags and flush.
// High-water-mark tracking is built only when STREAMING_FIFO_MAXCOUNT_EN is defined.
module streaming_fifo_param
  import streaming_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 784,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned CW       = cnt_width(DEPTH)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             flush,
  input  logic             maxcount_clr,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    maxcount,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_nxt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          af_q;
  logic          ae_q;
  logic          push_c;
  logic          pop_c;
  logic          we_c;

  assign push_c = in0_V_TVALID & in_ready_q;
  assign pop_c  = out_valid_q & out_V_TREADY;
  assign we_c   = push_c & ~flush;

  // Next pointer/count; flush overrides any handshake in the same cycle.
  always_comb begin
    count_nxt  = count_q;
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push_c) begin
        wr_ptr_nxt = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (pop_c) begin
        rd_ptr_nxt = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      case ({push_c, pop_c})
        2'b10:   count_nxt = count_q + CW'(1);
        2'b01:   count_nxt = count_q - CW'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Status flags are derived from next_count so they line up with count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      af_q        <= (AF_THRESH == 0);
      ae_q        <= 1'b1;
    end else begin
      count_q     <= count_nxt;
      wr_ptr_q    <= wr_ptr_nxt;
      rd_ptr_q    <= rd_ptr_nxt;
      in_ready_q  <= (count_nxt != CW'(DEPTH));
      out_valid_q <= (count_nxt != '0);
      af_q        <= (32'(count_nxt) >= AF_THRESH);
      ae_q        <= (32'(count_nxt) <= AE_THRESH);
    end
  end

`ifdef STREAMING_FIFO_MAXCOUNT_EN
  logic [CW-1:0] maxcount_q;

  // High-water mark; a clear reloads the occupancy rather than zero.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      maxcount_q <= '0;
    end else if (maxcount_clr) begin
      maxcount_q <= count_nxt;
    end else if (count_nxt > maxcount_q) begin
      maxcount_q <= count_nxt;
    end
  end

  assign maxcount = maxcount_q;
`else
  logic unused_maxcount_clr;

  assign unused_maxcount_clr = maxcount_clr;
  assign maxcount            = '0;
`endif

  streaming_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (ap_clk),
    .we    (we_c),
    .waddr (wr_ptr_q),
    .wdata (in0_V_TDATA),
    .raddr (rd_ptr_q),
    .rdata (out_V_TDATA)
  );

  assign in0_V_TREADY = in_ready_q;
  assign out_V_TVALID = out_valid_q;
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_streaming_fifo_param.sv
// Scoreboard bench for streaming_fifo_param: a queue-based reference model is
// stepped at each falling edge and compared against every DUT output.
module tb_streaming_fifo_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 784;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef STREAMING_FIFO_MAXCOUNT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             flush;
  logic             maxcount_clr;
  logic [WIDTH-1:0] in0_V_TDATA;
  logic             in0_V_TVALID;
  logic             in0_V_TREADY;
  logic [WIDTH-1:0] out_V_TDATA;
  logic             out_V_TVALID;
  logic             out_V_TREADY;
  logic [CW-1:0]    count;
  logic [CW-1:0]    maxcount;
  logic             almost_full;
  logic             almost_empty;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb_q[$];
  int               m_max = 0;
  int               m_size;
  bit               m_push;
  bit               m_pop;

  streaming_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .flush        (flush),
    .maxcount_clr (maxcount_clr),
    .in0_V_TDATA  (in0_V_TDATA),
    .in0_V_TVALID (in0_V_TVALID),
    .in0_V_TREADY (in0_V_TREADY),
    .out_V_TDATA  (out_V_TDATA),
    .out_V_TVALID (out_V_TVALID),
    .out_V_TREADY (out_V_TREADY),
    .count        (count),
    .maxcount     (maxcount),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: compare, then advance the model by the
  // handshakes that the coming rising edge will perform.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      sb_q.delete();
      m_max = 0;
      chk("rst_count", 32'(count), 0);
      chk("rst_maxcount", 32'(maxcount), 0);
      chk("rst_ready", 32'(in0_V_TREADY), 1);
      chk("rst_valid", 32'(out_V_TVALID), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);
    end else begin
      m_size = sb_q.size();
      chk("count", 32'(count), 32'(m_size));
      chk("ready", 32'(in0_V_TREADY), 32'(m_size != DEPTH));
      chk("valid", 32'(out_V_TVALID), 32'(m_size != 0));
      chk("af", 32'(almost_full), 32'(m_size >= AF));
      chk("ae", 32'(almost_empty), 32'(m_size <= AE));
      chk("maxcount", 32'(maxcount), MC_EN ? 32'(m_max) : 32'd0);
      if (m_size != 0) chk("data", 32'(out_V_TDATA), 32'(sb_q[0]));
      m_push = in0_V_TVALID && (m_size < DEPTH);
      m_pop  = out_V_TREADY && (m_size != 0);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_pop) void'(sb_q.pop_front());
        if (m_push) sb_q.push_back(in0_V_TDATA);
      end
      m_size = sb_q.size();
      if (maxcount_clr) m_max = m_size;
      else if (m_size > m_max) m_max = m_size;
    end
  end

  // Apply one cycle of inputs, returning just after the rising edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic f, input logic c);
    in0_V_TVALID = v;
    in0_V_TDATA  = d;
    out_V_TREADY = r;
    flush        = f;
    maxcount_clr = c;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    ap_rst_n     = 1'b0;
    flush        = 1'b0;
    maxcount_clr = 1'b0;
    in0_V_TDATA  = '0;
    in0_V_TVALID = 1'b0;
    out_V_TREADY = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    idle();

    // Three pushes with the output stalled.
    for (int i = 1; i <= 3; i++) drive(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    idle();
    chk("t1_count", 32'(count), 3);
    chk("t1_data", 32'(out_V_TDATA), 32'h0001);
    chk("t1_ae", 32'(almost_empty), 0);
    chk("t1_max", 32'(maxcount), MC_EN ? 32'd3 : 32'd0);

    // Fill to capacity, then pop while pushing into a full FIFO.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (DEPTH + 2) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), DEPTH);
    chk("full_ready", 32'(in0_V_TREADY), 0);
    chk("full_af", 32'(almost_full), 1);
    drive(1'b1, WIDTH'($urandom), 1'b1, 1'b0, 1'b0);
    chk("full_pop_count", 32'(count), DEPTH - 1);
    drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    chk("refill_count", 32'(count), DEPTH);

    // Random streaming across several pointer wraps, with rare flush/clear.
    for (int i = 0; i < 4000; i++) begin
      int vp;
      int rp;
      vp = (i < 2000) ? 70 : 40;
      rp = (i < 2000) ? 45 : 75;
      drive($urandom_range(0, 99) < vp, WIDTH'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 499) == 0, $urandom_range(0, 299) == 0);
    end

    // Simultaneous push and pop at count 3.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(16'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'(16'h20 + i), 1'b1, 1'b0, 1'b0);
      chk("pp_count", 32'(count), 3);
    end
    chk("pp_data", 32'(out_V_TDATA), 32'h0021);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with both handshakes active, then clear the high-water mark.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, WIDTH'($urandom), 1'b1, 1'b1, 1'b0);
    chk("fl_count", 32'(count), 0);
    chk("fl_valid", 32'(out_V_TVALID), 0);
    chk("fl_max", 32'(maxcount), MC_EN ? 32'd10 : 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_max", 32'(maxcount), 0);

    // Asynchronous reset mid-transfer at count 7.
    for (int i = 0; i < 7; i++) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    chk("ar_pre_count", 32'(count), 7);
    in0_V_TVALID = 1'b1;
    out_V_TREADY = 1'b1;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_valid", 32'(out_V_TVALID), 0);
    chk("ar_ready", 32'(in0_V_TREADY), 1);
    chk("ar_ae", 32'(almost_empty), 1);
    chk("ar_max", 32'(maxcount), 0);
    in0_V_TVALID = 1'b0;
    out_V_TREADY = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    repeat (8) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/streaming_fifo_param.md
# streaming_fifo_param

Parametrised successor to the fixed-geometry streaming FIFOs between dataflow layers. The block buffers an AXI-Stream-style data channel with configurable width and depth, including depths that are not a power of two (e.g. 784). It adds almost-full and almost-empty flags, a synchronous flush, and optional high-water-mark tracking with a clear input. It is instantiated on inter-layer streams wherever back-pressure decoupling or FIFO sizing telemetry is needed.

## Interface
Parameters:
- WIDTH, 16: data width in bits, ≥1.
- DEPTH, 784: storage capacity in words, ≥2, any integer.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- CW (localparam): $clog2(DEPTH+1), width of the count buses.

Ports:
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all stored words.
- maxcount_clr  in  1  synchronous reset of maxcount to the current count.
- in0_V_TDATA  in  WIDTH  input data.
- in0_V_TVALID  in  1  input valid.
- in0_V_TREADY  out  1  input ready.
- out_V_TDATA  out  WIDTH  output data.
- out_V_TVALID  out  1  output valid.
- out_V_TREADY  in  1  output ready.
- count  out  CW  number of words currently stored.
- maxcount  out  CW  high-water mark of count.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.

## Operation
- push = in0_V_TVALID & in0_V_TREADY; pop = out_V_TVALID & out_V_TREADY.
- Storage is a DEPTH-entry array with write pointer wr_ptr and read pointer rd_ptr, each in 0..DEPTH-1. A pointer at DEPTH-1 wraps to 0 on increment; there is no power-of-two masking.
- in0_V_TREADY = (count != DEPTH). out_V_TVALID = (count != 0). out_V_TDATA = mem[rd_ptr], combinational read.
- count update: push only gives +1; pop only gives −1; push and pop in the same cycle leaves count unchanged and advances both pointers.
- When full, push is impossible and a pop is still honoured. When empty, pop is impossible, a push is honoured, and there is no bypass to the output.
- flush takes priority over push and pop. It sets count, wr_ptr and rd_ptr to 0. Any push in that cycle is dropped, but in0_V_TREADY is still driven as normal. Memory contents are not cleared.
- maxcount is updated to next_count whenever next_count > maxcount. When maxcount_clr is set, it loads next_count instead. Flush does not clear maxcount.
- almost_full and almost_empty are registered from next_count, so they are coincident with count.
- Once asserted, out_V_TDATA and out_V_TVALID stay stable until pop, as AXI-Stream requires.

## Timing
- Reset values: count=0, maxcount=0, pointers=0, in0_V_TREADY=1, out_V_TVALID=0, almost_empty=1, almost_full=0 (or 1 if AF_THRESH=0). out_V_TDATA is don't-care.
- Latency: a word pushed at edge N is valid on the output after edge N, i.e. in cycle N+1. Minimum transit time is 1 cycle.
- Throughput is 1 word per cycle sustained when the FIFO is neither empty nor full.
- An asynchronous reset in mid-stream drops all contents immediately, with no handshake. Release of ap_rst_n must be synchronised externally.

## Configuration
- STREAMING_FIFO_MAXCOUNT_EN
  - Defined: the maxcount register and maxcount_clr behave as above.
  - Undefined: maxcount is tied to 0, maxcount_clr is ignored, and no tracking logic is synthesised. Port list is unchanged.

## Structure
- Package streaming_fifo_pkg holds:
  - a function cnt_width(depth) returning $clog2(depth+1);
  - a function ptr_inc(ptr, depth) that wraps to 0 at depth-1.
- One sub-module, streaming_fifo_mem: a DEPTH×WIDTH array with a single write port and a combinational read port. This keeps the storage mappable to LUTRAM or BRAM independently of control.

## Test plan
- Reset then 3 pushes (0x0001, 0x0002, 0x0003) with out_V_TREADY=0 → count=3, out_V_TDATA=0x0001, almost_empty=0 (AE_THRESH=2), maxcount=3.
- DEPTH=784: push 784 words → in0_V_TREADY=0, count=784, almost_full=1 from count 782. Pop 1 with push asserted in the same cycle → count=783 with no push; next cycle push is accepted.
- DEPTH=5: stream 20 words with randomly toggling valid and ready → output order matches input exactly, covering pointer wrap at 4→0 four times.
- Simultaneous push and pop at count=3 → count stays 3; in the following cycles out_V_TDATA shows the next words in order.
- Load 10 words, assert flush while push and pop are both active → next cycle count=0, out_V_TVALID=0, maxcount=10. Then assert maxcount_clr → maxcount=0.
- Assert ap_rst_n=0 asynchronously mid-transfer at count=7 → outputs go to their reset values before the next clock edge. With the macro undefined, maxcount stays 0 throughout all scenarios.
